// File: rtl/midi_pkg.sv
// Shared types, byte-class boundaries and classification helpers for the MIDI OUT transmitter.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] STATUS_MIN    = 8'h80;
  localparam logic [7:0] SYSCOMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN  = 8'hF8;

  function automatic logic is_channel_status(input logic [7:0] b);
    return (b >= STATUS_MIN) && (b < SYSCOMMON_MIN);
  endfunction

  function automatic logic is_realtime(input logic [7:0] b);
    return (b >= REALTIME_MIN);
  endfunction

endpackage

// File: rtl/midi_tx_if.sv
// Byte input channel of the MIDI OUT transmitter, driven by the MCU peripheral register.
// valid/ready: a byte transfers on a rising clk edge where valid and ready are both high;
// data must be stable while valid is high, and ready never depends on valid.
interface midi_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/midi_rs_filter.sv
// Running-status filter: decides whether an offered byte is a redundant channel-status
// byte, and keeps the stored status up to date on every accepted byte.
module midi_rs_filter
  import midi_pkg::*;
#(
  parameter int RUNNING_STATUS = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       accept_i,
  input  logic       rs_clear_i,
  output logic       drop_o
);

  logic [7:0] rs_q, rs_d;
  logic       rs_valid_q, rs_valid_d;

  // A clear on the same edge wins, so a matching byte is never dropped against a stale status.
  assign drop_o = (RUNNING_STATUS != 0) && is_channel_status(data_i) &&
                  rs_valid_q && !rs_clear_i && (data_i == rs_q);

  always_comb begin
    rs_d       = rs_q;
    rs_valid_d = rs_valid_q;
    if (rs_clear_i) begin
      rs_valid_d = 1'b0;
    end
    if (accept_i) begin
      if (is_channel_status(data_i)) begin
        rs_d       = data_i;
        rs_valid_d = 1'b1;
      end else if ((data_i >= SYSCOMMON_MIN) && !is_realtime(data_i)) begin
        rs_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs_q       <= 8'h00;
      rs_valid_q <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rs_valid_q <= rs_valid_d;
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: accepts bytes over valid/ready and sends 8N1 frames at BAUD,
// optionally dropping repeated channel-status bytes (running status).
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ       = 16_000_000,
  parameter int BAUD           = 31250,
  parameter int RUNNING_STATUS = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  midi_tx_if.slave  bus,
  input  logic      rs_clear_i,
  output logic      midi_o,
  output logic      busy_o,
  output tx_state_t dbg_state_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  // The IDLE cycle in which the next byte can be accepted is the last stop-bit cycle,
  // so STOP itself lasts one cycle less and back-to-back frames are exactly 10 bits long.
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          accept;
  logic          drop;

  assign bus.ready   = !rst_i && (state_q == IDLE);
  assign accept      = bus.valid && bus.ready;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

  midi_rs_filter #(
    .RUNNING_STATUS (RUNNING_STATUS)
  ) u_rs_filter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (bus.data),
    .accept_i   (accept),
    .rs_clear_i (rs_clear_i),
    .drop_o     (drop)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !drop) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = 3'd0;
          shift_d = bus.data;
        end
      end
      START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    midi_o = 1'b1;
    if (state_q == START) begin
      midi_o = 1'b0;
    end else if (state_q == DATA) begin
      midi_o = shift_q[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: a fast instance (16 clocks/bit) with a line decoder for streams,
// plus default-rate instances with and without running status for exact frame timing.
module tb_midi_tx;
  import midi_pkg::*;

  localparam int F_CPB = 16;
  localparam int D_CPB = 512;

  typedef struct {
    logic [7:0] data;
    logic       clr;
    logic       sent;
    logic       last;
    int         frames;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  midi_tx_if f_bus ();
  midi_tx_if d_bus ();
  midi_tx_if n_bus ();
  logic      f_rs_clear, d_rs_clear, n_rs_clear;
  logic      f_midi, d_midi, n_midi;
  logic      f_busy, d_busy, n_busy;
  tx_state_t f_state, d_state, n_state;

  midi_tx #(.CLK_FREQ(F_CPB * 31250), .BAUD(31250), .RUNNING_STATUS(1)) u_fast (
    .clk_i(clk), .rst_i(rst), .bus(f_bus), .rs_clear_i(f_rs_clear),
    .midi_o(f_midi), .busy_o(f_busy), .dbg_state_o(f_state)
  );

  midi_tx u_def (
    .clk_i(clk), .rst_i(rst), .bus(d_bus), .rs_clear_i(d_rs_clear),
    .midi_o(d_midi), .busy_o(d_busy), .dbg_state_o(d_state)
  );

  midi_tx #(.RUNNING_STATUS(0)) u_nrs (
    .clk_i(clk), .rst_i(rst), .bus(n_bus), .rs_clear_i(n_rs_clear),
    .midi_o(n_midi), .busy_o(n_busy), .dbg_state_o(n_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: bytes expected on the fast line, consumed by the decoder
  logic [7:0] exp_q[$];
  int rx_frames = 0;

  initial begin : decoder
    logic [7:0] b;
    logic       saw_rst;
    logic       start_bit;
    logic       stop_bit;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (f_midi === 1'b0 && rst === 1'b0) begin
        saw_rst = 1'b0;
        for (int k = 0; k < F_CPB / 2; k++) begin
          @(negedge clk);
          saw_rst |= rst;
        end
        start_bit = f_midi;
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < F_CPB; k++) begin
            @(negedge clk);
            saw_rst |= rst;
          end
          b[i] = f_midi;
        end
        for (int k = 0; k < F_CPB; k++) begin
          @(negedge clk);
          saw_rst |= rst;
        end
        stop_bit = f_midi;
        if (!saw_rst) begin
          rx_frames++;
          check("rx_start_bit", 32'(start_bit), 32'd0);
          check("rx_stop_bit", 32'(stop_bit), 32'd1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got frame 0x%02h, expected no frame", b);
          end else begin
            want = exp_q.pop_front();
            check("rx_byte", 32'(b), 32'(want));
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle budget exhausted, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks (entered and left on a falling edge)
  task automatic f_wait_ready(input int limit, input string name);
    int k = 0;
    while (f_bus.ready !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(f_bus.ready), 32'd1);
  endtask

  task automatic f_send(input logic [7:0] d, input logic clr, input logic sent,
                        input logic push, output int acc);
    f_bus.data  = d;
    f_bus.valid = 1'b1;
    f_wait_ready(20 * F_CPB, "send_ready");
    f_rs_clear = clr;
    @(negedge clk);
    acc        = cyc;
    f_rs_clear = 1'b0;
    if (push && sent) exp_q.push_back(d);
    check($sformatf("busy_after_%02h", d), 32'(f_busy), 32'(sent));
  endtask

  task automatic f_idle();
    f_bus.valid = 1'b0;
    f_wait_ready(20 * F_CPB, "idle_ready");
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[$];

  task automatic add(input logic [7:0] d, input logic clr, input logic sent,
                     input logic last, input int frames);
    vec_t v;
    v.data = d; v.clr = clr; v.sent = sent; v.last = last; v.frames = frames;
    vecs.push_back(v);
  endtask

  initial begin : main
    int acc, prev_acc, frames0, k;
    logic prev_sent, first;
    logic [7:0] byte_90;
    logic exp_midi;

    f_bus.data = 8'h00; f_bus.valid = 1'b0; f_rs_clear = 1'b0;
    d_bus.data = 8'h00; d_bus.valid = 1'b0; d_rs_clear = 1'b0;
    n_bus.data = 8'h00; n_bus.valid = 1'b0; n_rs_clear = 1'b0;
    byte_90 = 8'h90;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(f_bus.ready), 32'd0);
    check("midi_in_reset", 32'(f_midi), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(f_bus.ready), 32'd1);
    check("reset_busy", 32'(f_busy), 32'd0);
    check("reset_state", 32'(f_state), 32'(IDLE));
    check("reset_def_midi", 32'(d_midi), 32'd1);

    // Default rate: one 0x90 frame, checked every cycle
    d_bus.data  = 8'h90;
    d_bus.valid = 1'b1;
    @(negedge clk);
    d_bus.valid = 1'b0;
    k = 0;
    for (int n = 1; n <= 10 * D_CPB; n++) begin
      if (n <= D_CPB) exp_midi = 1'b0;
      else if (n <= 9 * D_CPB) exp_midi = byte_90[(n - D_CPB - 1) / D_CPB];
      else exp_midi = 1'b1;
      if (d_midi !== exp_midi || d_bus.ready !== (n == 10 * D_CPB) ||
          d_busy !== (n < 10 * D_CPB)) k++;
      if (n == 1)                check("def_first_low", 32'(d_midi), 32'd0);
      if (n == D_CPB)            check("def_last_start", 32'(d_midi), 32'd0);
      if (n == 9 * D_CPB)        check("def_bit7", 32'(d_midi), 32'd1);
      if (n == 9 * D_CPB + 1)    check("def_stop", 32'(d_midi), 32'd1);
      if (n == 10 * D_CPB - 1)   check("def_ready_early", 32'(d_bus.ready), 32'd0);
      if (n == 10 * D_CPB)       check("def_ready_back", 32'(d_bus.ready), 32'd1);
      if (n < 10 * D_CPB) @(negedge clk);
    end
    check("def_frame_bad_cycles", 32'(k), 32'd0);

    // RUNNING_STATUS=0: repeated 0x90 is sent twice, 10 bits apart
    n_bus.data  = 8'h90;
    n_bus.valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      check("nrs_busy", 32'(n_busy), 32'd1);
      if (f == 1) n_bus.valid = 1'b0;
      k = 1;
      while (n_bus.ready !== 1'b1 && k < 6000) begin
        @(negedge clk);
        k++;
      end
      check("nrs_ready_cycles", 32'(k), 32'(10 * D_CPB));
    end

    // Table-driven streams on the fast instance
    add(8'h90, 1, 1, 0, 0); add(8'h3C, 0, 1, 0, 0); add(8'h64, 0, 1, 0, 0);
    add(8'h90, 0, 0, 0, 0); add(8'h3E, 0, 1, 0, 0); add(8'h64, 0, 1, 1, 5);
    add(8'h90, 1, 1, 0, 0); add(8'hF8, 0, 1, 0, 0); add(8'h90, 0, 0, 1, 2);
    add(8'h90, 1, 1, 0, 0); add(8'hF0, 0, 1, 0, 0); add(8'h90, 0, 1, 1, 3);
    add(8'h90, 1, 1, 0, 0); add(8'h90, 1, 1, 1, 2);
    add(8'h80, 1, 1, 0, 0); add(8'h7F, 0, 1, 0, 0); add(8'hFF, 0, 1, 0, 0);
    add(8'h80, 0, 0, 0, 0); add(8'hEF, 0, 1, 0, 0); add(8'hEF, 0, 0, 0, 0);
    add(8'hF7, 0, 1, 0, 0); add(8'hEF, 0, 1, 1, 6);

    frames0 = rx_frames; first = 1'b1; prev_acc = 0; prev_sent = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      f_send(vecs[i].data, vecs[i].clr, vecs[i].sent, 1'b1, acc);
      if (!first) check($sformatf("accept_gap_%0d", i), 32'(acc - prev_acc),
                        prev_sent ? 32'(10 * F_CPB) : 32'd1);
      first = 1'b0; prev_acc = acc; prev_sent = vecs[i].sent;
      if (vecs[i].last) begin
        f_idle();
        check($sformatf("stream_frames_%0d", i), 32'(rx_frames - frames0), 32'(vecs[i].frames));
        frames0 = rx_frames;
        first = 1'b1;
      end
    end

    // Standalone rs_clear pulse between two 0x90, then a repeat that must drop
    frames0 = rx_frames;
    f_send(8'h90, 1, 1, 1, acc);
    f_idle();
    f_rs_clear = 1'b1;
    @(negedge clk);
    f_rs_clear = 1'b0;
    f_send(8'h90, 0, 1, 1, acc);
    f_idle();
    f_send(8'h90, 0, 0, 1, acc);
    f_idle();
    check("pulse_frames", 32'(rx_frames - frames0), 32'd2);

    // Reset during data bit 3 of 0x55
    frames0 = rx_frames;
    f_send(8'h55, 0, 1, 0, acc);
    f_bus.valid = 1'b0;
    repeat (4 * F_CPB + F_CPB / 2) @(negedge clk);
    check("rst_bit3_state", 32'(f_state), 32'(DATA));
    check("rst_bit3_line", 32'(f_midi), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midi_high", 32'(f_midi), 32'd1);
    check("rst_busy_low", 32'(f_busy), 32'd0);
    check("rst_ready_low", 32'(f_bus.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_back", 32'(f_bus.ready), 32'd1);
    repeat (12 * F_CPB) @(negedge clk);
    check("rst_no_frame", 32'(rx_frames - frames0), 32'd0);
    f_send(8'h55, 0, 1, 1, acc);
    prev_acc = acc;
    f_send(8'h90, 0, 1, 1, acc);
    check("rst_gap", 32'(acc - prev_acc), 32'(10 * F_CPB));
    f_idle();
    check("rst_after_frames", 32'(rx_frames - frames0), 32'd2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
